bnn_sequencer: RTL and testbench

Sequential controller for the 2-2-1 binary neural network: evaluates both hidden neurons and the output neuron on one shared multiply-accumulate datapath, one term per cycle, under a start/done handshake. Sits between the input/stimulus logic and the network weight/bias registers. Replaces the fully parallel evaluation when the design is resource-bound. With weights {20,20,-20,-20,20,20} and biases {-30,10,-10} it computes XNOR of x0 and x1.

---
 rtl/bnn_pkg.sv | 17 +
 rtl/bnn_mac.sv | 40 ++++
 rtl/bnn_sequencer.sv | 125 ++++++++++++
 tb/tb_bnn_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and constants for the 2-2-1 binary neural network sequencer.
package bnn_pkg;

   parameter int unsigned W = 16;
   localparam int unsigned NUM_NEURONS = 3;

   typedef logic signed [W-1:0] bnn_w_t;
   // Two guard bits: bias plus two weights can never overflow.
   typedef logic signed [W+1:0] bnn_acc_t;

   typedef enum logic [2:0] {StIdle, StLoad, StMac0, StMac1, StAct} bnn_state_e;

   function automatic bnn_acc_t sext(input bnn_w_t v);
      return {{2{v[W-1]}}, v};
   endfunction

endpackage

// File: rtl/bnn_mac.sv
// Shared accumulator for the sequencer: clear, load bias, add gated weight, >0 compare.
module bnn_mac
   import bnn_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   clr_i,
   input  logic   load_i,
   input  logic   add_i,
   input  logic   gate_i,
   input  bnn_w_t bias_i,
   input  bnn_w_t weight_i,
   output logic   pos_o
);

   bnn_acc_t acc_d, acc_q;

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (load_i) begin
         acc_d = sext(bias_i);
      end else if (add_i && gate_i) begin
         acc_d = acc_q + sext(weight_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // Strictly positive: zero activates to 0.
   assign pos_o = !acc_q[W+1] && (|acc_q);

endmodule

// File: rtl/bnn_sequencer.sv
// Evaluates both hidden neurons then the output neuron on one shared MAC,
// one term per cycle, under a start/done handshake.
module bnn_sequencer
   import bnn_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         x0_i,
   input  logic         x1_i,
   input  bnn_w_t [5:0] wt_i,
   input  bnn_w_t [2:0] b_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         out_o,
   output logic [1:0]   h_o
);

   localparam logic [1:0] LastN = 2'(NUM_NEURONS - 1);

   bnn_state_e state_d, state_q;
   logic [1:0] n_d, n_q;
   logic [1:0] xin_d, xin_q;
   logic [1:0] h_d, h_q;
   logic       out_d, out_q;
   logic       busy_d, busy_q;
   logic       done_d, done_q;

   logic       mac_clr, mac_load, mac_add, op_sel, mac_pos;
   logic [1:0] ops;
   logic [2:0] widx;

   // Output neuron consumes the hidden activations of this evaluation.
   assign ops  = (n_q == LastN) ? h_q : xin_q;
   assign widx = {n_q, op_sel};

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      xin_d    = xin_q;
      h_d      = h_q;
      out_d    = out_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      mac_clr  = 1'b0;
      mac_load = 1'b0;
      mac_add  = 1'b0;
      op_sel   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StLoad;
               xin_d   = {x1_i, x0_i};
               n_d     = 2'd0;
               busy_d  = 1'b1;
               mac_clr = 1'b1;
            end
         end
         StLoad: begin
            mac_load = 1'b1;
            state_d  = StMac0;
         end
         StMac0: begin
            mac_add = 1'b1;
            state_d = StMac1;
         end
         StMac1: begin
            mac_add = 1'b1;
            op_sel  = 1'b1;
            state_d = StAct;
         end
         StAct: begin
            if (n_q == LastN) begin
               out_d   = mac_pos;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else begin
               h_d[n_q[0]] = mac_pos;
               n_d         = n_q + 2'd1;
               state_d     = StLoad;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         n_q     <= '0;
         xin_q   <= '0;
         h_q     <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         xin_q   <= xin_d;
         h_q     <= h_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   bnn_mac u_mac (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (mac_clr),
      .load_i   (mac_load),
      .add_i    (mac_add),
      .gate_i   (ops[op_sel]),
      .bias_i   (b_i[n_q]),
      .weight_i (wt_i[widx]),
      .pos_o    (mac_pos)
   );

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign out_o  = out_q;
   assign h_o    = h_q;

endmodule

// File: tb/tb_bnn_sequencer.sv
// Self-checking bench: vector table, handshake/reset corner cases, randomized
// evaluations against an arithmetic model of the network.
module tb_bnn_sequencer;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             x0, x1;
   logic [5:0][15:0] wt;
   logic [2:0][15:0] b;
   logic             busy, done, out;
   logic [1:0]       h;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   bnn_sequencer dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .x0_i    (x0),
      .x1_i    (x1),
      .wt_i    (wt),
      .b_i     (b),
      .busy_o  (busy),
      .done_o  (done),
      .out_o   (out),
      .h_o     (h)
   );

   typedef struct {
      bit               x0;
      bit               x1;
      logic [5:0][15:0] w;
      logic [2:0][15:0] bb;
      bit [1:0]         eh;
      bit               eo;
   } vec_t;

   vec_t tbl[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [5:0][15:0] mkw(input int a0, a1, a2, a3, a4, a5);
      logic [5:0][15:0] r;
      r[0] = a0[15:0]; r[1] = a1[15:0]; r[2] = a2[15:0];
      r[3] = a3[15:0]; r[4] = a4[15:0]; r[5] = a5[15:0];
      return r;
   endfunction

   function automatic logic [2:0][15:0] mkb(input int a0, a1, a2);
      logic [2:0][15:0] r;
      r[0] = a0[15:0]; r[1] = a1[15:0]; r[2] = a2[15:0];
      return r;
   endfunction

   // Network computed directly from the neuron equations with integer sums.
   function automatic void model(input bit mx0, mx1, input logic [5:0][15:0] w,
                                 input logic [2:0][15:0] bb,
                                 output bit [1:0] mh, output bit mo);
      int s;
      for (int n = 0; n < 2; n++) begin
         s = int'($signed(bb[n]));
         if (mx0) s += int'($signed(w[2*n]));
         if (mx1) s += int'($signed(w[2*n+1]));
         mh[n] = (s > 0);
      end
      s = int'($signed(bb[2]));
      if (mh[0]) s += int'($signed(w[4]));
      if (mh[1]) s += int'($signed(w[5]));
      mo = (s > 0);
   endfunction

   // One evaluation; optional x toggling while busy and a stray start at T+5.
   task automatic run_eval(input string tag, input bit ix0, ix1, input bit toggle,
                           input bit poke);
      int cnt;
      x0 = ix0; x1 = ix1; start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_at_accept"}, busy, 1);
      cnt = 0;
      while (!done && cnt < 40) begin
         start = (poke && cnt == 4);
         if (toggle) {x0, x1} = 2'($urandom);
         tick();
         cnt++;
      end
      start = 1'b0;
      check({tag, "_latency"}, cnt, 12);
      check({tag, "_busy_with_done"}, busy, 0);
      if (poke) begin
         tick();
         check({tag, "_poke_ignored"}, busy, 0);
      end
   endtask

   initial begin
      bit [1:0] mh;
      bit       mo;
      int       cnt;

      tbl[0] = '{0, 0, mkw(20, 20, -20, -20, 20, 20), mkb(-30, 10, -10), 2'b10, 1};
      tbl[1] = '{0, 1, mkw(20, 20, -20, -20, 20, 20), mkb(-30, 10, -10), 2'b00, 0};
      tbl[2] = '{1, 0, mkw(20, 20, -20, -20, 20, 20), mkb(-30, 10, -10), 2'b00, 0};
      tbl[3] = '{1, 1, mkw(20, 20, -20, -20, 20, 20), mkb(-30, 10, -10), 2'b01, 1};
      tbl[4] = '{1, 1, mkw(0, 0, 0, 0, 0, 0), mkb(0, 0, 0), 2'b00, 0};
      tbl[5] = '{1, 1, mkw(0, 0, 0, 0, 0, 0), mkb(0, 0, 1), 2'b00, 1};
      tbl[6] = '{1, 1, mkw(-32768, -32768, -32768, -32768, -32768, -32768),
                 mkb(-32768, -32768, -32768), 2'b00, 0};
      tbl[7] = '{1, 1, mkw(32767, 32767, 32767, 32767, 32767, 32767),
                 mkb(32767, 32767, 32767), 2'b11, 1};

      rst = 1'b1; start = 1'b0; x0 = 1'b0; x1 = 1'b0;
      wt = tbl[0].w; b = tbl[0].bb;
      tick(); tick();
      rst = 1'b0;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_out", out, 0);
      check("reset_h", h, 0);

      foreach (tbl[i]) begin
         wt = tbl[i].w; b = tbl[i].bb;
         run_eval($sformatf("vec%0d", i), tbl[i].x0, tbl[i].x1, 0, i == 1);
         check($sformatf("vec%0d_h", i), h, tbl[i].eh);
         check($sformatf("vec%0d_out", i), out, tbl[i].eo);
      end

      // x toggling while busy must not disturb the latched 00 result.
      wt = tbl[0].w; b = tbl[0].bb;
      run_eval("toggle", 0, 0, 1, 0);
      check("toggle_out", out, 1);
      check("toggle_h", h, 2'b10);

      // start held high: re-accepted in the done cycle, next done 12 later.
      x0 = 1'b0; x1 = 1'b1; start = 1'b1;
      tick();
      cnt = 0;
      while (!done && cnt < 40) begin tick(); cnt++; end
      check("b2b_first_latency", cnt, 12);
      check("b2b_first_out", out, 0);
      x0 = 1'b1; x1 = 1'b1;
      tick();
      check("b2b_reaccept_busy", busy, 1);
      cnt = 0;
      while (!done && cnt < 40) begin tick(); cnt++; end
      start = 1'b0;
      check("b2b_second_latency", cnt, 12);
      check("b2b_second_out", out, 1);

      // Reset mid-evaluation sampled at T+6 discards the result.
      x0 = 1'b0; x1 = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_out", out, 0);
      check("midrst_h", h, 0);
      cnt = 0;
      repeat (14) begin tick(); cnt += done; end
      check("midrst_no_done", cnt, 0);
      run_eval("post_rst", 1, 1, 0, 0);
      check("post_rst_out", out, 1);
      check("post_rst_h", h, 2'b01);

      for (int i = 0; i < 40; i++) begin
         logic [5:0][15:0] rw;
         logic [2:0][15:0] rb;
         bit               rx0, rx1;
         for (int k = 0; k < 6; k++) rw[k] = 16'($urandom);
         for (int k = 0; k < 3; k++) rb[k] = 16'($urandom);
         if (i % 4 == 0) for (int k = 0; k < 6; k++) rw[k] = 16'($urandom_range(0, 64) - 32);
         if (i % 4 == 0) for (int k = 0; k < 3; k++) rb[k] = 16'($urandom_range(0, 64) - 32);
         rx0 = 1'($urandom); rx1 = 1'($urandom);
         wt = rw; b = rb;
         model(rx0, rx1, rw, rb, mh, mo);
         run_eval($sformatf("rnd%0d", i), rx0, rx1, 1'($urandom), 0);
         check($sformatf("rnd%0d_h", i), h, mh);
         check($sformatf("rnd%0d_out", i), out, mo);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
